// File: rtl/cpu_core.sv
// Multicycle CPU core: RST/FETCH/EXEC/MEM/HALT sequencer, 8-entry register file,
// ALU, and a single ready/ack memory port with unlimited wait states.
module cpu_core #(
    parameter int unsigned    DW       = 16,
    parameter int unsigned    AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          hlt,
    output logic          illegal
);

    typedef enum logic [2:0] {S_RST, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    typedef enum logic [3:0] {
        OP_ALU  = 4'd0,
        OP_LDI  = 4'd1,
        OP_LD   = 4'd2,
        OP_ST   = 4'd3,
        OP_SKIP = 4'd4,
        OP_JMP  = 4'd5,
        OP_ADDI = 4'd6,
        OP_HLT  = 4'd15
    } op_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc, pc_nx;
    logic [15:0]   ir;
    logic [DW-1:0] regs [8];

    logic          load_ir, wr_en, set_hlt, set_ill;
    logic [DW-1:0] wr_data;

    op_t           op;
    logic [2:0]    rd, rs0, rs1, fn;
    logic [DW-1:0] a, b, dval, imm, alu_y, d;
    logic [DW:0]   diff_ext;
    logic          borrow, ovf, lt_s, take;
    logic [AW-1:0] pc_inc1, pc_inc2;

    assign op  = op_t'(ir[15:12]);
    assign rd  = ir[11:9];
    assign rs0 = ir[8:6];
    assign rs1 = ir[5:3];
    assign fn  = ir[2:0];

    assign a    = (rs0 == 3'd0) ? '0 : regs[rs0];
    assign b    = (rs1 == 3'd0) ? '0 : regs[rs1];
    assign dval = (rd  == 3'd0) ? '0 : regs[rd];
    assign imm  = {{(DW-9){ir[8]}}, ir[8:0]};

    assign pc_inc1 = pc + AW'(1);
    assign pc_inc2 = pc + AW'(2);

    // Signed LT corrects the sign of the difference for overflow; unsigned uses the borrow.
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign d        = diff_ext[DW-1:0];
    assign borrow   = diff_ext[DW];
    assign ovf      = (a[DW-1] ^ b[DW-1]) & (d[DW-1] ^ a[DW-1]);
    assign lt_s     = d[DW-1] ^ ovf;

    always_comb begin
        alu_y = '0;
        case (fn)
            3'd0: alu_y = a + b;
            3'd1: alu_y = a - b;
            3'd2: alu_y = a & b;
            3'd3: alu_y = a | b;
            3'd4: alu_y = a ^ b;
            3'd5: alu_y = a << 1;
            3'd6: alu_y = a >> 1;
            default: alu_y = a;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (fn)
            3'd0: take = (d == '0);
            3'd1: take = (d != '0);
            3'd2: take = lt_s;
            3'd3: take = ~lt_s;
            3'd4: take = borrow;
            3'd5: take = ~borrow;
            3'd6: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        load_ir   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        set_hlt   = 1'b0;
        set_ill   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        case (state)
            S_RST: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    load_ir  = 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                pc_nx    = pc_inc1;
                case (op)
                    OP_ALU:  begin wr_en = 1'b1; wr_data = alu_y; end
                    OP_LDI:  begin wr_en = 1'b1; wr_data = imm; end
                    OP_ADDI: begin wr_en = 1'b1; wr_data = dval + imm; end
                    OP_LD, OP_ST: begin
                        pc_nx    = pc;
                        state_nx = S_MEM;
                    end
                    OP_SKIP: pc_nx = take ? pc_inc2 : pc_inc1;
                    OP_JMP: begin
                        wr_en   = 1'b1;
                        wr_data = DW'(pc_inc1);
                        pc_nx   = AW'(a);
                    end
                    OP_HLT: begin
                        pc_nx    = pc;
                        set_hlt  = 1'b1;
                        state_nx = S_HALT;
                    end
                    default: set_ill = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = AW'(a);
                if (op == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_wdata = b;
                end
                if (mem_ack) begin
                    if (op == OP_LD) begin
                        wr_en   = 1'b1;
                        wr_data = mem_rdata;
                    end
                    pc_nx    = pc_inc1;
                    state_nx = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_RST;
            pc      <= RESET_PC;
            ir      <= '0;
            hlt     <= 1'b0;
            illegal <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (load_ir) ir <= mem_rdata[15:0];
            if (set_hlt) hlt <= 1'b1;
            if (set_ill) illegal <= 1'b1;
            if (wr_en && rd != 3'd0) regs[rd] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: default, narrow-address and wide-data instances,
// each with its own word memory and a log of completed memory handshakes.
module tb_cpu_core;

    logic clk;
    logic rst_m, rst_a, rst_w;
    int   checks, errors, we_cnt;

    logic        ld_en;
    int          ld_sel;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ack_block, ack_force;

    // default instance
    logic        req_m, we_m, ack_m, hlt_m, ill_m;
    logic [15:0] addr_m, wdata_m, rdata_m;
    logic [15:0] mem_m [256];
    int          n_m;
    int          log_addr_m [64];
    logic        log_we_m [64];
    logic [15:0] log_d_m [64];

    // AW=4, RESET_PC=15 instance
    logic        req_a, we_a, ack_a, hlt_a, ill_a;
    logic [3:0]  addr_a;
    logic [15:0] wdata_a, rdata_a;
    logic [15:0] mem_a [16];
    int          n_a;
    int          log_addr_a [64];

    // DW=32 instance
    logic        req_w, we_w, ack_w, hlt_w, ill_w;
    logic [15:0] addr_w;
    logic [31:0] wdata_w, rdata_w;
    logic [31:0] mem_w [256];
    int          n_w;
    int          log_addr_w [64];

    assign ack_m   = ack_force | (req_m & ~ack_block);
    assign ack_a   = req_a;
    assign ack_w   = req_w;
    assign rdata_m = mem_m[addr_m[7:0]];
    assign rdata_a = mem_a[addr_a];
    assign rdata_w = mem_w[addr_w[7:0]];

    cpu_core dut_m (
        .clk(clk), .reset(rst_m), .mem_req(req_m), .mem_we(we_m), .mem_addr(addr_m),
        .mem_wdata(wdata_m), .mem_rdata(rdata_m), .mem_ack(ack_m), .hlt(hlt_m), .illegal(ill_m)
    );

    cpu_core #(.DW(16), .AW(4), .RESET_PC(4'd15)) dut_a (
        .clk(clk), .reset(rst_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ack(ack_a), .hlt(hlt_a), .illegal(ill_a)
    );

    cpu_core #(.DW(32), .AW(16), .RESET_PC(16'd0)) dut_w (
        .clk(clk), .reset(rst_w), .mem_req(req_w), .mem_we(we_w), .mem_addr(addr_w),
        .mem_wdata(wdata_w), .mem_rdata(rdata_w), .mem_ack(ack_w), .hlt(hlt_w), .illegal(ill_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en && ld_sel == 0) mem_m[ld_addr] <= ld_data[15:0];
        else if (rst_m && req_m && ack_m && we_m) mem_m[addr_m[7:0]] <= wdata_m;
        if (!rst_m) n_m <= 0;
        else if (req_m && ack_m && n_m < 64) begin
            log_addr_m[n_m] <= int'(addr_m);
            log_we_m[n_m]   <= we_m;
            log_d_m[n_m]    <= wdata_m;
            n_m             <= n_m + 1;
        end
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel == 1) mem_a[ld_addr[3:0]] <= ld_data[15:0];
        else if (rst_a && req_a && ack_a && we_a) mem_a[addr_a] <= wdata_a;
        if (!rst_a) n_a <= 0;
        else if (req_a && ack_a && n_a < 64) begin
            log_addr_a[n_a] <= int'(addr_a);
            n_a             <= n_a + 1;
        end
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel == 2) mem_w[ld_addr] <= ld_data;
        else if (rst_w && req_w && ack_w && we_w) mem_w[addr_w[7:0]] <= wdata_w;
        if (!rst_w) n_w <= 0;
        else if (req_w && ack_w && n_w < 64) begin
            log_addr_w[n_w] <= int'(addr_w);
            n_w             <= n_w + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int sel, input int addr, input logic [31:0] data);
        ld_sel  = sel;
        ld_addr = addr[7:0];
        ld_data = data;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic wait_hlt(input int sel, input int budget, output int cyc);
        logic h;
        h   = 1'b0;
        cyc = 0;
        while (!h && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (sel == 0 && we_m) we_cnt++;
            case (sel)
                0: h = hlt_m;
                1: h = hlt_a;
                default: h = hlt_w;
            endcase
        end
        check("hlt_reached", {63'd0, h}, 64'd1);
    endtask

    int cyc;
    int exp_seq3 [7] = '{0, 1, 2, 4, 5, 7, 8};
    int exp_seq4 [9] = '{0, 1, 2, 'h30, 3, 'h40, 4, 'h40, 5};
    int exp_seq5 [6] = '{15, 0, 1, 3, 3, 4};
    logic found;

    initial begin
        checks = 0; errors = 0; we_cnt = 0;
        rst_m = 1'b0; rst_a = 1'b0; rst_w = 1'b0;
        ld_en = 1'b0; ld_sel = 0; ld_addr = '0; ld_data = '0;
        ack_block = 1'b0; ack_force = 1'b0;
        repeat (2) @(posedge clk);

        // 1: LDI/LDI/ADD/HLT with zero-wait ack
        load(0, 0, 32'h1205); load(0, 1, 32'h15FD); load(0, 2, 32'h0650); load(0, 3, 32'hF000);
        @(negedge clk);
        check("rst_req",   {63'd0, req_m},   64'd0);
        check("rst_we",    {63'd0, we_m},    64'd0);
        check("rst_addr",  {48'd0, addr_m},  64'd0);
        check("rst_wdata", {48'd0, wdata_m}, 64'd0);
        check("rst_hlt",   {63'd0, hlt_m},   64'd0);
        check("rst_ill",   {63'd0, ill_m},   64'd0);
        check("rst_ir",    {48'd0, dut_m.ir}, 64'd0);
        rst_m = 1'b1;
        wait_hlt(0, 50, cyc);
        check("t1_cycles", 64'(cyc), 64'd9);
        check("t1_fetches", 64'(n_m), 64'd4);
        check("t1_r1", {48'd0, dut_m.regs[1]}, 64'h5);
        check("t1_r2", {48'd0, dut_m.regs[2]}, 64'hFFFD);
        check("t1_r3", {48'd0, dut_m.regs[3]}, 64'h2);
        check("t1_ill", {63'd0, ill_m}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("t1_req_after_hlt", {63'd0, req_m}, 64'd0);
        end

        // 2: fetch ack held off for three cycles
        rst_m = 1'b0;
        load(0, 0, 32'h1205); load(0, 1, 32'hF000);
        ack_block = 1'b1;
        @(negedge clk);
        rst_m = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t2_req_hold",  {63'd0, req_m},  64'd1);
            check("t2_addr_hold", {48'd0, addr_m}, 64'd0);
            check("t2_ir_hold",   {48'd0, dut_m.ir}, 64'd0);
            check("t2_r1_hold",   {48'd0, dut_m.regs[1]}, 64'd0);
        end
        ack_block = 1'b0;
        @(negedge clk);
        check("t2_exec_req", {63'd0, req_m}, 64'd0);
        check("t2_ir",       {48'd0, dut_m.ir}, 64'h1205);
        check("t2_r1_pre",   {48'd0, dut_m.regs[1]}, 64'd0);
        @(negedge clk);
        check("t2_r1",        {48'd0, dut_m.regs[1]}, 64'h5);
        check("t2_next_addr", {48'd0, addr_m}, 64'd1);
        ack_block = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t2_no_hlt",   {63'd0, hlt_m}, 64'd0);
            check("t2_addr1_hold", {48'd0, addr_m}, 64'd1);
        end
        ack_block = 1'b0;
        wait_hlt(0, 10, cyc);
        check("t2_accesses", 64'(n_m), 64'd2);

        // 3: signed/unsigned/always/never skips
        rst_m = 1'b0;
        load(0, 0, 32'h13FF); load(0, 1, 32'h1401); load(0, 2, 32'h4052);
        load(0, 3, 32'hF000); load(0, 4, 32'h4054); load(0, 5, 32'h4056);
        load(0, 6, 32'hF000); load(0, 7, 32'h4057); load(0, 8, 32'hF000);
        @(negedge clk);
        rst_m = 1'b1;
        wait_hlt(0, 60, cyc);
        check("t3_cycles", 64'(cyc), 64'd15);
        check("t3_fetches", 64'(n_m), 64'd7);
        for (int i = 0; i < 7; i++) check("t3_fetch_addr", 64'(log_addr_m[i]), 64'(exp_seq3[i]));

        // 4: store then load back through memory
        rst_m = 1'b0;
        load(0, 0, 32'h1240); load(0, 1, 32'h1830); load(0, 2, 32'h2500);
        load(0, 3, 32'h3050); load(0, 4, 32'h2640); load(0, 5, 32'hF000);
        load(0, 'h30, 32'hABCD); load(0, 'h40, 32'h0000);
        @(negedge clk);
        we_cnt = 0;
        rst_m  = 1'b1;
        wait_hlt(0, 60, cyc);
        check("t4_cycles", 64'(cyc), 64'd16);
        check("t4_we_cycles", 64'(we_cnt), 64'd1);
        check("t4_accesses", 64'(n_m), 64'd9);
        for (int i = 0; i < 9; i++) begin
            check("t4_addr", 64'(log_addr_m[i]), 64'(exp_seq4[i]));
            check("t4_we", {63'd0, log_we_m[i]}, (i == 5) ? 64'd1 : 64'd0);
        end
        check("t4_st_data", {48'd0, log_d_m[5]}, 64'hABCD);
        check("t4_mem40", {48'd0, mem_m[8'h40]}, 64'hABCD);
        check("t4_r3", {48'd0, dut_m.regs[3]}, 64'hABCD);

        // 5: AW=4 wrap from 15 to 0, jump-and-link
        load(1, 15, 32'h1A03); load(1, 0, 32'h0007); load(1, 1, 32'h5140);
        load(1, 3, 32'h5B40); load(1, 4, 32'hF000);
        @(negedge clk);
        check("t5_rst_addr", {60'd0, addr_a}, 64'd15);
        rst_a = 1'b1;
        wait_hlt(1, 50, cyc);
        check("t5_cycles", 64'(cyc), 64'd13);
        check("t5_fetches", 64'(n_a), 64'd6);
        for (int i = 0; i < 6; i++) check("t5_fetch_addr", 64'(log_addr_a[i]), 64'(exp_seq5[i]));
        check("t5_r5", {48'd0, dut_a.regs[5]}, 64'd4);
        check("t5_r0", {48'd0, dut_a.regs[0]}, 64'd0);

        // 6: reset asserted during a stalled LD
        rst_m = 1'b0;
        load(0, 0, 32'h1207); load(0, 1, 32'h2440); load(0, 7, 32'h1111);
        @(negedge clk);
        rst_m = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req_m && addr_m == 16'd7) found = 1'b1;
        end
        ack_block = 1'b1;
        check("t6_ld_seen", {63'd0, found}, 64'd1);
        repeat (2) @(negedge clk);
        check("t6_r1_before", {48'd0, dut_m.regs[1]}, 64'd7);
        #2 rst_m = 1'b0; ack_force = 1'b1;
        #1 check("t6_req_drop", {63'd0, req_m}, 64'd0);
        check("t6_r1_cleared", {48'd0, dut_m.regs[1]}, 64'd0);
        repeat (2) @(negedge clk);
        rst_m = 1'b1; ack_force = 1'b0; ack_block = 1'b0;
        #1 check("t6_rst_state_req", {63'd0, req_m}, 64'd0);
        @(negedge clk);
        check("t6_refetch_req",  {63'd0, req_m},  64'd1);
        check("t6_refetch_addr", {48'd0, addr_m}, 64'd0);
        check("t6_r2", {48'd0, dut_m.regs[2]}, 64'd0);
        check("t6_ir", {48'd0, dut_m.ir}, 64'd0);

        // 7: DW=32 sign extension and illegal opcode
        load(2, 0, 32'hDEAD13FF); load(2, 1, 32'h00009000);
        load(2, 2, 32'hBEEF1405); load(2, 3, 32'h1234F000);
        @(negedge clk);
        check("t7_rst_ill", {63'd0, ill_w}, 64'd0);
        rst_w = 1'b1;
        wait_hlt(2, 50, cyc);
        check("t7_cycles", 64'(cyc), 64'd9);
        check("t7_r1", {32'd0, dut_w.regs[1]}, 64'hFFFFFFFF);
        check("t7_r2", {32'd0, dut_w.regs[2]}, 64'd5);
        check("t7_ill", {63'd0, ill_w}, 64'd1);
        check("t7_fetches", 64'(n_w), 64'd4);
        for (int i = 0; i < 4; i++) check("t7_fetch_addr", 64'(log_addr_w[i]), 64'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
